conv33_window_gen: RTL and testbench
====================================

// Module: conv33_window_gen
// PURPOSE
//  Sliding-window generator feeding the 3x3 conv input stage. Accepts one raster-scan frame
//  (IMG_H x IMG_W pixels), one pixel per handshake, buffers two lines, and emits every
//  valid (unpadded) 3x3 window: (IMG_H-2)*(IMG_W-2) windows per frame, row-major order.
//  Downstream it drives valid/ready and in_r_c of the conv33 input stage.
// PARAMETERS
//  DATA_WIDTH  8   pixel width, unsigned
//  IMG_W       28  frame width in pixels, >=3
//  IMG_H       28  frame height in pixels, >=3
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  start      in   1           begin a frame; sampled only in IDLE
//  done       out  1           one-cycle pulse after last window handshaked
//  pix_valid  in   1           upstream pixel valid
//  pix_ready  out  1           pixel accepted when pix_valid & pix_ready
//  pix_in     in   DATA_WIDTH  pixel, raster order
//  valid_out  out  1           window valid toward conv input stage
//  ready_in   in   1           conv input stage can take window
//  out_r_c    out  DATA_WIDTH  9 ports, r,c in 0..2; r=0 is row y-2, c=0 is column x-2
// BEHAVIOUR
//  - Reset: state=IDLE, row/col counters=0, window regs=0, valid_out=0, pix_ready=0, done=0.
//    Line-buffer RAMs are not reset; stale contents are never emitted.
//  - FSM: IDLE -(start)-> RUN -(last pixel accepted)-> DRAIN -(no pending window)-> DONE -> IDLE.
//    DONE lasts 1 cycle; done=1 only in DONE. start outside IDLE ignored.
//    Entering RUN clears row/col. If last pixel makes no window pending, DRAIN exits next cycle.
//  - pix_ready = (state==RUN) & (~valid_out | ready_in). Combinational from ready_in only.
//  - Accept at (row,col), pixel p:
//      taps: top=lb1[col], mid=lb0[col], bot=p; then lb1[col]<=lb0[col], lb0[col]<=p.
//      window shifts left per row: w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=tap[r].
//      col wraps IMG_W-1 -> 0 with row+1. Last pixel = (IMG_H-1, IMG_W-1).
//  - valid_out next cycle: set on accept with row>=2 & col>=2 (latency 1).
//    Cleared on ready_in handshake with no new emitting accept. Window regs are the outputs.
//  - Held window: out_* and valid_out stable while valid_out & ~ready_in.
//    No pixel accepted during that hold.
//  - Simultaneous output handshake + emitting accept: valid_out stays 1, window updates.
//    Full throughput is 1 pixel/cycle.
//  - Columns 0,1 of each row shift in but do not emit (no wrap artefacts).
//  - rst mid-frame: immediate return to reset values; next frame needs a new start.
// STRUCTURE
//  - Shared package: pixel typedef (DATA_WIDTH) and FSM state encoding
//    (IDLE/RUN/DRAIN/DONE), shared with conv33 ctrl.
//  - One sub-module: conv33_line_buffer (IMG_W x DATA_WIDTH, 1R1W same-address,
//    read-before-write), instantiated twice (lb0, lb1).
//  - Counters sized $clog2(IMG_W), $clog2(IMG_H).
// TESTING  (IMG_W=4, IMG_H=4, pixels 0..15 in raster order)
//  1. start, pix_valid=1, ready_in=1 -> 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11},
//     {4..6,8..10,12..14}, {5..7,9..11,13..15}. done 1 cycle after last handshake.
//  2. As 1, ready_in low 3 cycles at first window -> out_* hold {0,1,2,4,5,6,8,9,10}.
//     pix_ready=0 during hold. Same 4 windows, no loss or duplication.
//  3. pix_valid toggled every other cycle -> identical window sequence; valid_out gaps only.
//  4. rst asserted after pixel 9 -> all outputs 0 next edge. New start + full frame reproduces test 1.
//  5. start pulsed during RUN -> ignored. Back-to-back frames via start in IDLE after done
//     -> test 1 output repeated twice.
//  6. IMG_W=3, IMG_H=3 -> one window {0..8}, then done.

Source files
------------

// File: rtl/conv33_window_gen_pkg.sv
// Types and FSM encoding shared by the 3x3 window generator and the conv33 control path.
package conv33_window_gen_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Flat index of window tap (r, c); r=0 is the oldest row, c=0 the oldest column.
    function automatic int win_idx(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/conv33_line_buffer.sv
// One image line of storage: single address, combinational read of the old word,
// write of the new word at the clock edge (read-before-write).
module conv33_line_buffer #(
    parameter  int DEPTH      = 28,
    parameter  int DATA_WIDTH = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Not reset: every word is rewritten before it can reach an emitted window.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv33_window_gen.sv
// Raster-scan 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// emitting every unpadded window of one frame in row-major order.
module conv33_window_gen
    import conv33_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] out_0_0,
    output logic [DATA_WIDTH-1:0] out_0_1,
    output logic [DATA_WIDTH-1:0] out_0_2,
    output logic [DATA_WIDTH-1:0] out_1_0,
    output logic [DATA_WIDTH-1:0] out_1_1,
    output logic [DATA_WIDTH-1:0] out_1_2,
    output logic [DATA_WIDTH-1:0] out_2_0,
    output logic [DATA_WIDTH-1:0] out_2_1,
    output logic [DATA_WIDTH-1:0] out_2_2,
    output state_e                dbg_state
);

    // Handshakes: a pixel moves when pix_valid & pix_ready, a window moves when
    // valid_out & ready_in; valid_out and the window hold until their handshake.

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] win_q [WIN_TAPS];
    logic [DATA_WIDTH-1:0] win_d [WIN_TAPS];

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  emit;
    logic                  last_pix;
    logic [DATA_WIDTH-1:0] tap_top;
    logic [DATA_WIDTH-1:0] tap_mid;

    assign accept   = pix_valid & pix_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign emit     = accept & (row_q >= RW'(2)) & (col_q >= CW'(2));
    assign last_pix = accept & row_last & col_last;

    // lb0 holds the previous line, lb1 the line before it.
    conv33_line_buffer #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) u_lb0 (
        .clk     (clk),
        .addr    (col_q),
        .we      (accept),
        .wr_data (pix_in),
        .rd_data (tap_mid)
    );

    conv33_line_buffer #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
        .clk     (clk),
        .addr    (col_q),
        .we      (accept),
        .wr_data (tap_mid),
        .rd_data (tap_top)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_pix) state_d = ST_DRAIN;
            ST_DRAIN: if (~valid_q | ready_in) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = (state_q == ST_RUN) & (~valid_q | ready_in);
        done      = (state_q == ST_DONE);
        dbg_state = state_q;
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        win_d   = win_q;

        if ((state_q == ST_IDLE) && start) begin
            row_d = '0;
            col_d = '0;
        end

        if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
                win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
            end
            win_d[win_idx(0, 2)] = tap_top;
            win_d[win_idx(1, 2)] = tap_mid;
            win_d[win_idx(2, 2)] = pix_in;

            if (col_last) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // A new window replacing a consumed one keeps valid high without a bubble.
        if (emit) begin
            valid_d = 1'b1;
        end else if (ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign valid_out = valid_q;
    assign out_0_0   = win_q[0];
    assign out_0_1   = win_q[1];
    assign out_0_2   = win_q[2];
    assign out_1_0   = win_q[3];
    assign out_1_1   = win_q[4];
    assign out_1_2   = win_q[5];
    assign out_2_0   = win_q[6];
    assign out_2_1   = win_q[7];
    assign out_2_2   = win_q[8];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Bench for conv33_window_gen: a 4x4 instance checked against a window scoreboard,
// and a 3x3 instance for the single-window frame.
module tb_conv33_window_gen;
  import conv33_window_gen_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic clk;
  logic rst;

  logic       start, done, pix_valid, pix_ready, valid_out, ready_in;
  logic [7:0] pix_in;
  logic [7:0] o00, o01, o02, o10, o11, o12, o20, o21, o22;
  state_e     st;

  logic       start_b, done_b, pix_valid_b, pix_ready_b, valid_out_b, ready_in_b;
  logic [7:0] pix_in_b;
  logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
  state_e     st_b;

  int vectors = 0;
  int errors = 0;
  int win_cnt = 0;
  int stall_cnt = 0;

  logic [71:0] exp_q[$];

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .out_0_0(o00), .out_0_1(o01), .out_0_2(o02),
    .out_1_0(o10), .out_1_1(o11), .out_1_2(o12),
    .out_2_0(o20), .out_2_1(o21), .out_2_2(o22),
    .dbg_state(st)
  );

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_in(pix_in_b),
    .valid_out(valid_out_b), .ready_in(ready_in_b),
    .out_0_0(b00), .out_0_1(b01), .out_0_2(b02),
    .out_1_0(b10), .out_1_1(b11), .out_1_2(b12),
    .out_2_0(b20), .out_2_1(b21), .out_2_2(b22),
    .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: push on emitting pixel accept, pop on window handshake
  int          mon_k = 0;
  logic        prev_stall = 1'b0;
  logic [71:0] prev_win = '0;

  always @(negedge clk) begin
    logic [71:0] cur;
    logic [71:0] e;
    logic [71:0] got;
    int r, c;
    cur = {o00, o01, o02, o10, o11, o12, o20, o21, o22};
    if (rst) begin
      exp_q.delete();
      mon_k = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (valid_out !== 1'b1 || cur !== prev_win) begin
          errors++;
          $display("FAIL hold: valid=%b win=%h required valid=1 win=%h", valid_out, cur, prev_win);
        end
      end
      if (valid_out && !ready_in) begin
        stall_cnt++;
        vectors++;
        if (pix_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_pix_ready: got %b required 0", pix_ready);
        end
      end
      if (valid_out && ready_in) begin
        vectors++;
        win_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected: got %h with empty queue", cur);
        end else begin
          got = exp_q.pop_front();
          if (cur !== got) begin
            errors++;
            $display("FAIL window: got %h required %h", cur, got);
          end
        end
      end
      if (pix_valid && pix_ready) begin
        r = mon_k / W;
        c = mon_k % W;
        if (r >= 2 && c >= 2) begin
          e = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e[(8 - (i * 3 + j)) * 8 +: 8] = 8'((r - 2 + i) * W + (c - 2 + j));
          exp_q.push_back(e);
        end
        mon_k = (mon_k + 1) % NPIX;
      end
      prev_stall = valid_out && !ready_in;
      prev_win = cur;
    end
  end

  // driver: one frame on the 4x4 instance, starting with a start pulse
  task automatic drive_frame(input int valid_mode, input int ready_mode, input int start_mid,
                             input int stop_after, output int done_cnt, output int done_lag,
                             output int last_hs, output int timed_out);
    int k, hold, done_cyc;
    logic seen_first, acc;
    k = 0; hold = 0; done_cyc = -1; seen_first = 1'b0;
    done_cnt = 0; last_hs = -1; done_lag = -1; timed_out = 0;
    @(posedge clk); #1;
    start = 1'b1; pix_valid = 1'b0; ready_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pix_valid = (k < NPIX) && (valid_mode == 0 || (cyc % 2) == 0);
      pix_in = 8'(k);
      if (ready_mode == 1 && valid_out && !seen_first) begin
        seen_first = 1'b1;
        hold = 3;
      end
      ready_in = (hold == 0);
      if (hold > 0) hold--;
      start = (start_mid != 0 && cyc == 5);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (valid_out && ready_in && done_cyc < 0) last_hs = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (acc) k++;
      if (stop_after > 0 && k == stop_after) break;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    pix_valid = 1'b0; start = 1'b0; ready_in = 1'b1;
    if (stop_after == 0 && done_cyc < 0) timed_out = 1;
    if (done_cyc >= 0) done_lag = done_cyc - last_hs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; pix_valid = 1'b0; pix_in = '0; ready_in = 1'b1;
    start_b = 1'b0; pix_valid_b = 1'b0; pix_in_b = '0; ready_in_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({valid_out, pix_ready, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: valid/ready/done=%b required 000", {valid_out, pix_ready, done});
    end
    vectors++;
    if ({o00, o01, o02, o10, o11, o12, o20, o21, o22} !== 72'h0) begin
      errors++;
      $display("FAIL reset_win: got %h required 0", {o00, o01, o02, o10, o11, o12, o20, o21, o22});
    end
    vectors++;
    if (st !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", st, ST_IDLE);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (pix_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: pix_ready=%b done=%b required 0 0", pix_ready, done);
    end
  endtask

  task automatic check_frame(input string name, input int w0, input int dc, input int dl,
                             input int to);
    vectors++;
    if (win_cnt - w0 !== 4) begin
      errors++;
      $display("FAIL %s_count: got %0d windows required 4", name, win_cnt - w0);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending: %0d windows left required 0", name, exp_q.size());
    end
    vectors++;
    if (to !== 0 || dc !== 1) begin
      errors++;
      $display("FAIL %s_done: timeout=%0d done cycles=%0d required 0 1", name, to, dc);
    end
    vectors++;
    if (dl !== 1) begin
      errors++;
      $display("FAIL %s_done_lag: got %0d required 1", name, dl);
    end
  endtask

  task automatic test_stream();
    int w0, dc, dl, lh, to;
    w0 = win_cnt;
    drive_frame(0, 0, 0, 0, dc, dl, lh, to);
    check_frame("stream", w0, dc, dl, to);
    vectors++;
    if (lh !== NPIX) begin
      errors++;
      $display("FAIL stream_throughput: last window handshake cycle %0d required %0d", lh, NPIX);
    end
  endtask

  task automatic test_stall();
    int w0, s0, dc, dl, lh, to;
    w0 = win_cnt;
    s0 = stall_cnt;
    drive_frame(0, 1, 0, 0, dc, dl, lh, to);
    check_frame("stall", w0, dc, dl, to);
    vectors++;
    if (stall_cnt - s0 !== 3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d required 3", stall_cnt - s0);
    end
  endtask

  task automatic test_valid_gaps();
    int w0, dc, dl, lh, to;
    w0 = win_cnt;
    drive_frame(1, 0, 0, 0, dc, dl, lh, to);
    check_frame("gaps", w0, dc, dl, to);
  endtask

  task automatic test_mid_reset();
    int w0, dc, dl, lh, to;
    drive_frame(0, 0, 0, 10, dc, dl, lh, to);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({valid_out, pix_ready, done} !== 3'b000 || st !== ST_IDLE) begin
      errors++;
      $display("FAIL midrst_ctl: valid/ready/done=%b state=%0d required 000 0",
               {valid_out, pix_ready, done}, st);
    end
    vectors++;
    if ({o00, o01, o02, o10, o11, o12, o20, o21, o22} !== 72'h0) begin
      errors++;
      $display("FAIL midrst_win: got %h required 0", {o00, o01, o02, o10, o11, o12, o20, o21, o22});
    end
    #1 rst = 1'b0;
    pix_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_restart: pix_ready=%b required 0", pix_ready);
    end
    pix_valid = 1'b0;
    w0 = win_cnt;
    drive_frame(0, 0, 0, 0, dc, dl, lh, to);
    check_frame("after_rst", w0, dc, dl, to);
  endtask

  task automatic test_back_to_back();
    int w0, dc, dl, lh, to;
    w0 = win_cnt;
    drive_frame(0, 0, 1, 0, dc, dl, lh, to);
    check_frame("start_ignored", w0, dc, dl, to);
    w0 = win_cnt;
    drive_frame(0, 0, 0, 0, dc, dl, lh, to);
    check_frame("back_to_back", w0, dc, dl, to);
  endtask

  task automatic test_small_frame();
    int k, got, dcnt, hs_cyc, d_cyc;
    logic acc;
    logic [71:0] cur;
    logic [71:0] e;
    k = 0; got = 0; dcnt = 0; hs_cyc = -1; d_cyc = -1;
    e = '0;
    for (int i = 0; i < 9; i++) e[(8 - i) * 8 +: 8] = 8'(i);
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      pix_valid_b = (k < 9);
      pix_in_b = 8'(k);
      @(negedge clk);
      acc = pix_valid_b && pix_ready_b;
      cur = {b00, b01, b02, b10, b11, b12, b20, b21, b22};
      if (valid_out_b && ready_in_b) begin
        got++;
        hs_cyc = cyc;
        vectors++;
        if (cur !== e) begin
          errors++;
          $display("FAIL small_window: got %h required %h", cur, e);
        end
      end
      if (done_b) begin
        dcnt++;
        if (d_cyc < 0) d_cyc = cyc;
      end
      @(posedge clk); #1;
      if (acc) k++;
      if (d_cyc >= 0 && cyc > d_cyc + 2) break;
    end
    pix_valid_b = 1'b0;
    vectors++;
    if (got !== 1 || dcnt !== 1) begin
      errors++;
      $display("FAIL small_counts: windows=%0d done cycles=%0d required 1 1", got, dcnt);
    end
    vectors++;
    if (d_cyc - hs_cyc !== 1) begin
      errors++;
      $display("FAIL small_done_lag: got %0d required 1", d_cyc - hs_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_valid_gaps();
    test_mid_reset();
    test_back_to_back();
    test_small_frame();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
